sha256_axil_master: RTL and testbench

//  AXI4-Lite initiator: the bus-master counterpart of the sha256 register slave.

---
 rtl/sha256_axil_pkg.sv | 44 ++++
 rtl/sha256_axil_timeout.sv | 44 ++++
 rtl/sha256_axil_master.sv | 230 +++++++++++++++++++++++
 tb/tb_sha256_axil_master.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_axil_pkg.sv
// ---------------------------------------------------------------------------
// sha256_axil_pkg
//   Shared constants for the sha256 AXI4-Lite master and its peers:
//   bus widths, AXI response codes, master FSM state encoding and the
//   register offset map of the sha256 register slave.
//   No ports (package).
// ---------------------------------------------------------------------------
package sha256_axil_pkg;

   localparam int AXI_ADDR_W = 16;
   localparam int AXI_DATA_W = 32;

   // AXI4-Lite response codes (BRESP/RRESP)
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Master FSM encoding, kept as plain constants for legacy tool flows
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WR    = 3'd1;
   localparam logic [2:0] ST_WR_B  = 3'd2;
   localparam logic [2:0] ST_RD_AR = 3'd3;
   localparam logic [2:0] ST_RD_R  = 3'd4;
   localparam logic [2:0] ST_RSP   = 3'd5;

   // Register map of the sha256 slave (byte offsets)
   localparam logic [7:0] REG_H0      = 8'h00;
   localparam logic [7:0] REG_H1      = 8'h04;
   localparam logic [7:0] REG_H2      = 8'h08;
   localparam logic [7:0] REG_H3      = 8'h0C;
   localparam logic [7:0] REG_H4      = 8'h10;
   localparam logic [7:0] REG_H5      = 8'h14;
   localparam logic [7:0] REG_H6      = 8'h18;
   localparam logic [7:0] REG_H7      = 8'h1C;
   localparam logic [7:0] REG_CONTROL = 8'h20;
   localparam logic [7:0] REG_RESULT  = 8'h24;
   localparam logic [7:0] REG_WINNER  = 8'h28;
   localparam logic [7:0] REG_R0      = 8'h2C;
   localparam logic [7:0] REG_R1      = 8'h30;
   localparam logic [7:0] REG_R2      = 8'h34;
   localparam logic [7:0] REG_R3      = 8'h38;

endpackage

// File: rtl/sha256_axil_timeout.sv
// ---------------------------------------------------------------------------
// sha256_axil_timeout
//   Saturating cycle counter guarding a bus transaction against a hung slave.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     i_clear      restart the count (command accepted)
//     i_enable     count this cycle (transaction outstanding on the bus)
//     o_expired    the cycle now ending is the TIMEOUT_CYCLES-th counted cycle
//                  (or later); never asserted when TIMEOUT_CYCLES == 0
// ---------------------------------------------------------------------------
module sha256_axil_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
   localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
   // Last count value before the limit: expiry is flagged while that cycle
   // is in progress so the FSM can leave at exactly TIMEOUT_CYCLES edges.
   localparam logic [CW-1:0] LIMIT_M1 = ENABLED ? CW'(TIMEOUT_CYCLES - 1) : '0;

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         // NOTE: state registers use non-blocking assignments so every
         // always_ff samples the pre-edge value of every other register.
         r_count <= '0;
      end else if (i_enable && (r_count != LIMIT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = ENABLED && i_enable && (r_count >= LIMIT_M1);

endmodule

// File: rtl/sha256_axil_master.sv
// ---------------------------------------------------------------------------
// sha256_axil_master
//   AXI4-Lite initiator. Accepts one command (write flag, address, data,
//   strobes) on a valid/ready stream, performs a single AXI4-Lite read or
//   write, and returns the response on a result stream. A hung slave is
//   recovered by a timeout that produces a SLVERR result with rsp_timeout=1.
//   Ports:
//     m_axi_aclk, m_axi_aresetn     clock, asynchronous active-low reset
//     cmd_valid/cmd_ready           command handshake (ready only when idle)
//     cmd_write/addr/wdata/wstrb    command payload
//     rsp_valid/rsp_ready           result handshake, payload held until taken
//     rsp_rdata/rsp_resp/rsp_timeout result payload
//     m_axi_aw*/w*/b*/ar*/r*        AXI4-Lite master channels
// ---------------------------------------------------------------------------
module sha256_axil_master
   import sha256_axil_pkg::*;
#(
   parameter int ADDR_WIDTH     = AXI_ADDR_W,
   parameter int DATA_WIDTH     = AXI_DATA_W,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  m_axi_aclk,
   input  logic                  m_axi_aresetn,
   // command stream
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   // result stream
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   // write address channel
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   // write data channel
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   // write response channel
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   // read address channel
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   // read data channel
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   logic [2:0]            r_state;
   logic                  r_cmd_ready;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [1:0]            r_rsp_resp;
   logic                  r_rsp_timeout;

   logic w_accept;
   logic w_aw_done;
   logic w_w_done;
   logic w_busy;
   logic w_progress;
   logic w_expired;

   assign w_accept  = cmd_valid && r_cmd_ready;
   // A write channel is finished once its valid is already low or its
   // handshake happens this cycle; AW and W complete in either order.
   assign w_aw_done = !r_awvalid || m_axi_awready;
   assign w_w_done  = !r_wvalid  || m_axi_wready;

   assign w_busy = (r_state == ST_WR)    || (r_state == ST_WR_B) ||
                   (r_state == ST_RD_AR) || (r_state == ST_RD_R);

   // Any handshake that advances the FSM this cycle; it beats an expiry
   // landing on the same edge.
   assign w_progress = ((r_state == ST_WR)    && w_aw_done && w_w_done) ||
                       ((r_state == ST_WR_B)  && m_axi_bvalid)          ||
                       ((r_state == ST_RD_AR) && m_axi_arready)         ||
                       ((r_state == ST_RD_R)  && m_axi_rvalid);

   sha256_axil_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (m_axi_aclk),
      .rst_n     (m_axi_aresetn),
      .i_clear   (w_accept),
      .i_enable  (w_busy),
      .o_expired (w_expired)
   );

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_state       <= ST_IDLE;
         r_cmd_ready   <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= RESP_OKAY;
         r_rsp_timeout <= 1'b0;
      end else if (w_busy && w_expired && !w_progress) begin
         // Hung slave: withdraw every bus request and report the failure.
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_rsp_valid   <= 1'b1;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= RESP_SLVERR;
         r_rsp_timeout <= 1'b1;
         r_state       <= ST_RSP;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // cmd_ready is registered so it reads 0 throughout reset and
               // rises on the first idle cycle afterwards.
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= cmd_addr;
                  r_wdata     <= cmd_wdata;
                  r_wstrb     <= cmd_wstrb;
                  if (cmd_write) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= ST_WR;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RD_AR;
                  end
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            ST_WR: begin
               if (w_aw_done && w_w_done) begin
                  r_awvalid <= 1'b0;
                  r_wvalid  <= 1'b0;
                  r_bready  <= 1'b1;
                  r_state   <= ST_WR_B;
               end else begin
                  if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
                  if (r_wvalid  && m_axi_wready)  r_wvalid  <= 1'b0;
               end
            end
            ST_WR_B: begin
               if (m_axi_bvalid) begin
                  r_bready      <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= '0;
                  r_rsp_resp    <= m_axi_bresp;
                  r_rsp_timeout <= 1'b0;
                  r_state       <= ST_RSP;
               end
            end
            ST_RD_AR: begin
               if (m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_R;
               end
            end
            ST_RD_R: begin
               if (m_axi_rvalid) begin
                  r_rready      <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= m_axi_rdata;
                  r_rsp_resp    <= m_axi_rresp;
                  r_rsp_timeout <= 1'b0;
                  r_state       <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign rsp_timeout   = r_rsp_timeout;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_araddr  = r_addr;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;

endmodule

// File: tb/tb_sha256_axil_master.sv
// ---------------------------------------------------------------------------
// tb_sha256_axil_master
//   Drives sha256_axil_master against a stall-configurable model of the
//   sha256 register slave. Expected results come from a word-level register
//   map kept in the bench, updated from the command stream.
// ---------------------------------------------------------------------------
module tb_sha256_axil_master;
   import sha256_axil_pkg::*;

   localparam int          TO         = 16;
   localparam logic [31:0] RESULT_VAL = 32'hDEADBEEF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [15:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [31:0] m_axi_wdata, m_axi_rdata;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;

   sha256_axil_master #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
   ) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- slave register map semantics ----------------
   function automatic logic [1:0] bus_resp(input logic [15:0] a);
      if (a[15:2] < 14'd15) return RESP_OKAY;
      else if (a < 16'h0100) return RESP_SLVERR;
      else return RESP_DECERR;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // ---------------- stall-configurable slave ----------------
   int   aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic hang = 1'b0;
   logic [31:0] slave_mem [16] = '{default: '0};
   logic        aw_got, w_got, ar_got;
   int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic [15:0] cap_awaddr, cap_araddr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_wstrb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || hang) begin
         m_axi_awready <= 1'b0; m_axi_wready <= 1'b0; m_axi_bvalid <= 1'b0;
         m_axi_arready <= 1'b0; m_axi_rvalid <= 1'b0;
         m_axi_bresp <= 2'b00; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
         aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
         aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      end else begin
         if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awready <= 1'b0; aw_got <= 1'b1; cap_awaddr <= m_axi_awaddr;
         end else if (m_axi_awvalid && !aw_got && !m_axi_awready) begin
            if (aw_wait >= aw_dly) m_axi_awready <= 1'b1; else aw_wait <= aw_wait + 1;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wready <= 1'b0; w_got <= 1'b1;
            cap_wdata <= m_axi_wdata; cap_wstrb <= m_axi_wstrb;
         end else if (m_axi_wvalid && !w_got && !m_axi_wready) begin
            if (w_wait >= w_dly) m_axi_wready <= 1'b1; else w_wait <= w_wait + 1;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0;
         end else if (aw_got && w_got && !m_axi_bvalid) begin
            if (b_wait >= b_dly) begin
               m_axi_bvalid <= 1'b1;
               m_axi_bresp  <= bus_resp(cap_awaddr);
               if (bus_resp(cap_awaddr) == RESP_OKAY && cap_awaddr[5:2] != 4'd9)
                  slave_mem[cap_awaddr[5:2]] <= merge(slave_mem[cap_awaddr[5:2]], cap_wdata, cap_wstrb);
            end else b_wait <= b_wait + 1;
         end
         if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arready <= 1'b0; ar_got <= 1'b1; cap_araddr <= m_axi_araddr;
         end else if (m_axi_arvalid && !ar_got && !m_axi_arready) begin
            if (ar_wait >= ar_dly) m_axi_arready <= 1'b1; else ar_wait <= ar_wait + 1;
         end
         if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rvalid <= 1'b0; ar_got <= 1'b0; ar_wait <= 0; r_wait <= 0;
         end else if (ar_got && !m_axi_rvalid) begin
            if (r_wait >= r_dly) begin
               m_axi_rvalid <= 1'b1;
               m_axi_rresp  <= bus_resp(cap_araddr);
               if (bus_resp(cap_araddr) != RESP_OKAY) m_axi_rdata <= '0;
               else if (cap_araddr[5:2] == 4'd9)      m_axi_rdata <= RESULT_VAL;
               else                                   m_axi_rdata <= slave_mem[cap_araddr[5:2]];
            end else r_wait <= r_wait + 1;
         end
      end
   end

   // ---------------- bus monitors ----------------
   int          aw_beats = 0, w_beats = 0, ar_beats = 0, stab_err = 0;
   logic [15:0] last_awaddr = '0, last_araddr = '0;
   logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
   logic [15:0] p_awaddr, p_araddr;
   logic [35:0] p_wpay;

   always @(posedge clk) begin
      if (m_axi_awvalid && m_axi_awready) begin aw_beats <= aw_beats + 1; last_awaddr <= m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready)   w_beats <= w_beats + 1;
      if (m_axi_arvalid && m_axi_arready) begin ar_beats <= ar_beats + 1; last_araddr <= m_axi_araddr; end
      // a pending request must stay asserted with an unchanged payload
      if (rst_n && !hang) begin
         if ((p_aw && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) ||
             (p_w  && (!m_axi_wvalid  || {m_axi_wstrb, m_axi_wdata} != p_wpay)) ||
             (p_ar && (!m_axi_arvalid || m_axi_araddr != p_araddr)))
            stab_err <= stab_err + 1;
      end
      p_aw <= m_axi_awvalid && !m_axi_awready; p_awaddr <= m_axi_awaddr;
      p_w  <= m_axi_wvalid  && !m_axi_wready;  p_wpay   <= {m_axi_wstrb, m_axi_wdata};
      p_ar <= m_axi_arvalid && !m_axi_arready; p_araddr <= m_axi_araddr;
   end

   // ---------------- reference register map ----------------
   logic [31:0] model_mem [16] = '{default: '0};

   function automatic logic [31:0] exp_read(input logic [15:0] a);
      if (bus_resp(a) != RESP_OKAY) return '0;
      if (a[5:2] == 4'd9) return RESULT_VAL;
      return model_mem[a[5:2]];
   endfunction

   // ---------------- command / response drivers ----------------
   task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int acc_cyc);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("cmd_ready_wait", 0, 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      @(negedge clk);
      acc_cyc   = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input int hold, output logic [31:0] rd, output logic [1:0] rs,
                          output logic to, output int rsp_cyc);
      int n;
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("rsp_wait", 0, 1);
      rsp_cyc = cyc; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rsp_hold", {rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout},
               {1'b1, 1'b0, rd, rs, to});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_taken", {rsp_valid, cmd_ready}, 2'b01);
   endtask

   task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold);
      int acc, rc, aw0, w0, ar0;
      logic [31:0] rd, exp_d;
      logic [1:0]  rs, exp_r;
      logic        to;
      aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;
      exp_r = bus_resp(addr);
      exp_d = wr ? 32'h0 : exp_read(addr);
      send_cmd(wr, addr, data, strb, acc);
      check("bus_start", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, wr ? 3'b110 : 3'b001);
      get_rsp(hold, rd, rs, to, rc);
      check("rsp_resp", rs, exp_r);
      check("rsp_rdata", rd, exp_d);
      check("rsp_timeout", to, 1'b0);
      check("beats", {8'(aw_beats - aw0), 8'(w_beats - w0), 8'(ar_beats - ar0)},
            wr ? 24'h010100 : 24'h000001);
      check("addr_fwd", wr ? last_awaddr : last_araddr, addr);
      if (wr && exp_r == RESP_OKAY && addr[5:2] != 4'd9)
         model_mem[addr[5:2]] = merge(model_mem[addr[5:2]], data, strb);
   endtask

   task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
      aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation did not finish");
   end

   // ---------------- main sequence ----------------
   initial begin
      int          acc, rc, n;
      logic [31:0] rd;
      logic [1:0]  rs;
      logic        to;
      logic        wr;
      logic [15:0] addr;

      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      set_dly(0, 0, 0, 0, 0);

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outs", {cmd_ready, rsp_valid, rsp_timeout, rsp_resp, m_axi_awvalid, m_axi_wvalid,
                           m_axi_bready, m_axi_arvalid, m_axi_rready, m_axi_awprot, m_axi_arprot}, '0);
      check("reset_data", {rsp_rdata, m_axi_awaddr, m_axi_wstrb}, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // single write then readback
      do_txn(1'b1, 16'h0000, 32'h6A09E667, 4'hF, 0);
      do_txn(1'b0, 16'h0000, '0, '0, 0);
      // slave-driven result register
      do_txn(1'b0, 16'h0024, '0, '0, 0);
      // W accepted 5 cycles after AW, B 3 cycles later
      set_dly(0, 5, 3, 0, 0);
      do_txn(1'b1, 16'h0004, 32'hBB67AE85, 4'hF, 0);
      set_dly(4, 0, 2, 3, 3);
      do_txn(1'b1, 16'h0010, 32'h510E527F, 4'hF, 0);
      set_dly(0, 0, 0, 0, 0);
      // result held while consumer stalls
      do_txn(1'b0, 16'h0004, '0, '0, 10);
      // partial strobes and error responses
      do_txn(1'b1, 16'h0004, 32'h11223344, 4'b0101, 0);
      do_txn(1'b0, 16'h0004, '0, '0, 0);
      do_txn(1'b1, 16'h0080, 32'hCAFEF00D, 4'hF, 0);
      do_txn(1'b0, 16'h0400, '0, '0, 0);

      // hung slave: write and read time out exactly TO cycles after accept
      hang = 1'b1;
      send_cmd(1'b1, 16'h0008, 32'h12345678, 4'hF, acc);
      get_rsp(0, rd, rs, to, rc);
      check("to_wr_latency", 64'(rc - acc), 64'(TO));
      check("to_wr_result", {rd, rs, to}, {32'h0, RESP_SLVERR, 1'b1});
      send_cmd(1'b0, 16'h0008, '0, '0, acc);
      get_rsp(0, rd, rs, to, rc);
      check("to_rd_latency", 64'(rc - acc), 64'(TO));
      check("to_rd_result", {rd, rs, to}, {32'h0, RESP_SLVERR, 1'b1});
      check("to_quiet", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, '0);
      hang = 1'b0;
      do_txn(1'b0, 16'h0008, '0, '0, 0);

      // rvalid arriving on the limit cycle wins over the timeout
      set_dly(0, 0, 0, 0, TO - 4);
      send_cmd(1'b0, 16'h0000, '0, '0, acc);
      get_rsp(0, rd, rs, to, rc);
      check("lim_hs_latency", 64'(rc - acc), 64'(TO));
      check("lim_hs_result", {rd, rs, to}, {model_mem[0], RESP_OKAY, 1'b0});
      // one cycle later loses: timeout, and the late rvalid is left untouched
      set_dly(0, 0, 0, 0, TO - 3);
      send_cmd(1'b0, 16'h0000, '0, '0, acc);
      get_rsp(0, rd, rs, to, rc);
      check("lim_to_latency", 64'(rc - acc), 64'(TO));
      check("lim_to_result", {rd, rs, to}, {32'h0, RESP_SLVERR, 1'b1});
      check("no_unsolicited", {m_axi_rvalid, m_axi_rready}, 2'b10);
      hang = 1'b1; @(negedge clk); hang = 1'b0;
      set_dly(0, 0, 0, 0, 0);

      // reset while waiting for B aborts the write with no result
      set_dly(0, 0, 8, 0, 0);
      send_cmd(1'b1, 16'h000C, 32'h11111111, 4'hF, acc);
      n = 0;
      while (!m_axi_bready && n < 20) begin @(negedge clk); n++; end
      check("reach_wr_b", m_axi_bready, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_outs", {cmd_ready, rsp_valid, rsp_timeout, rsp_resp, m_axi_awvalid, m_axi_wvalid,
                           m_axi_bready, m_axi_arvalid, m_axi_rready}, '0);
      check("abort_data", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_dly(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("abort_no_rsp", rsp_valid, 1'b0);
      do_txn(1'b0, 16'h000C, '0, '0, 0);
      do_txn(1'b1, 16'h000C, 32'h3C6EF372, 4'hF, 0);
      do_txn(1'b0, 16'h000C, '0, '0, 0);

      // randomized traffic with random stalls and consumer back-pressure
      for (int k = 0; k < 60; k++) begin
         set_dly($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 4));
         wr = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0:       addr = 16'h0040 + 16'($urandom_range(0, 40) * 4);
            1:       addr = 16'h0100 + 16'($urandom_range(0, 1000) * 4);
            default: addr = 16'($urandom_range(0, 14) * 4);
         endcase
         addr[1:0] = 2'($urandom_range(0, 3));
         do_txn(wr, addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end

      // final sweep of the whole map
      set_dly(0, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) do_txn(1'b0, 16'(i * 4), '0, '0, 0);

      check("payload_stable", 64'(stab_err), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
